mem_ctrl: RTL and testbench

Byte-wide RAM arbiter and controller sitting directly downstream of the MEM stage and beside the IF stage. It multiplexes the single synchronous byte-port RAM between MEM-stage byte transactions, forwarded combinationally with absolute priority, and IF-stage 32-bit instruction fetches, sequenced internally as four byte reads. Preempted fetches restart cleanly. Read data returns with the RAM's fixed one-cycle latency, so the MEM stage's request/capture cadence is preserved unchanged.

---
 rtl/mem_ctrl.sv | 80 ++++++++
 tb/tb_mem_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte RAM arbiter; MEM byte accesses win, IF word fetches run as four byte reads
module mem_ctrl #(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_req,
    input  logic              mem_r_w,
    input  logic [31:0]       mem_req_addr,
    input  logic [7:0]        mem_req_data,
    output logic [7:0]        memctrl_data,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    input  logic              if_flush,
    output logic              if_done,
    output logic [31:0]       if_inst,
    input  logic [7:0]        ram_din,
    output logic [7:0]        ram_dout,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr
);
    typedef enum logic [2:0] {S0, S1, S2, S3, S4, IDLE} state_t;
    state_t      state_q;
    logic [31:0] base_q;
    logic [7:0]  b0_q, b1_q, b2_q;
    logic        if_done_q;
    logic [31:0] if_inst_q;
    logic [31:0] fetch_addr;
    logic        issue;
    logic        unused_addr;
    // S0..S3 are encoded 0..3, so the low state bits are the byte offset being issued
    assign issue        = state_q inside {S0, S1, S2, S3};
    assign fetch_addr   = base_q + {30'd0, state_q[1:0]};
    assign memctrl_data = ram_din;
    assign if_done      = if_done_q;
    assign if_inst      = if_inst_q;
    assign unused_addr  = ^{mem_req_addr[31:ADDR_W], fetch_addr[31:ADDR_W]};
    // RAM port mux: reset blanks the port, MEM always wins, otherwise the fetch byte
    always_comb begin
        ram_a    = rst ? '0 : mem_req ? mem_req_addr[ADDR_W-1:0] : issue ? fetch_addr[ADDR_W-1:0] : '0;
        ram_wr   = !rst && mem_req && mem_r_w;
        ram_dout = (!rst && mem_req) ? mem_req_data : 8'd0;
    end
    // Fetch sequencer: each state captures the byte issued one cycle earlier
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            base_q    <= '0;
            b0_q      <= '0;
            b1_q      <= '0;
            b2_q      <= '0;
            if_done_q <= 1'b0;
            if_inst_q <= '0;
        end else begin
            if_done_q <= 1'b0;
            if (state_q == IDLE) begin
                if (if_req && !if_flush) begin
                    base_q  <= if_addr;
                    state_q <= S0;
                end
            end else if (if_flush || !if_req) begin
                state_q <= IDLE;
            end else if (mem_req && state_q != S4) begin
                state_q <= S0;
            end else begin
                case (state_q)
                    S0: state_q <= S1;
                    S1: begin b0_q <= ram_din; state_q <= S2; end
                    S2: begin b1_q <= ram_din; state_q <= S3; end
                    S3: begin b2_q <= ram_din; state_q <= S4; end
                    default: begin
                        if_inst_q <= {ram_din, b2_q, b1_q, b0_q};
                        if_done_q <= 1'b1;
                        state_q   <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: vector table, directed fetch sequences and random traffic against a word-level model
module tb_mem_ctrl;
    localparam int AW = 17;
    logic          clk = 1'b0;
    logic          rst, mem_req, mem_r_w, if_req, if_flush;
    logic [31:0]   mem_req_addr, if_addr;
    logic [7:0]    mem_req_data;
    logic [7:0]    memctrl_data, ram_dout;
    logic [7:0]    ram_din = 8'd0;
    logic          if_done, ram_wr;
    logic [31:0]   if_inst;
    logic [AW-1:0] ram_a;
    logic [7:0]    mem [0:(1<<AW)-1];
    int            n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    mem_ctrl #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_r_w(mem_r_w),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
        .memctrl_data(memctrl_data), .if_req(if_req), .if_addr(if_addr),
        .if_flush(if_flush), .if_done(if_done), .if_inst(if_inst),
        .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr)
    );

    // synchronous byte RAM with one-cycle read latency
    always @(posedge clk) begin
        if (ram_wr) mem[ram_a] <= ram_dout;
        ram_din <= mem[ram_a];
    end

    // word-level reference: a fetch needs four consecutive unpreempted issue cycles, then one completion cycle
    logic        m_act = 1'b0;
    int          m_cnt = 0;
    logic [31:0] m_base = '0;
    logic [7:0]  m_b [4];
    logic        e_done;
    logic [31:0] e_inst = '0;
    logic [7:0]  e_rd;
    logic [AW-1:0] s_a;
    logic        s_wr;
    logic [7:0]  s_d;
    logic [AW-1:0] a_seq [16];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic step(input logic r, mq, rw, input logic [31:0] ma, input logic [7:0] md,
                        input logic iq, fl, input logic [31:0] ia);
        logic [AW-1:0] ea;
        rst = r; mem_req = mq; mem_r_w = rw; mem_req_addr = ma; mem_req_data = md;
        if_req = iq; if_flush = fl; if_addr = ia;
        #1;
        s_a = ram_a; s_wr = ram_wr; s_d = ram_dout;
        ea = r ? '0 : mq ? ma[AW-1:0] : (m_act && m_cnt < 4) ? AW'(m_base + m_cnt) : '0;
        chk("ram_a", ram_a, ea);
        chk("ram_wr", ram_wr, !r && mq && rw);
        chk("ram_dout", ram_dout, (!r && mq) ? md : 8'd0);
        e_rd = mem[ea];
        e_done = 1'b0;
        if (r) begin
            m_act = 0; m_cnt = 0; m_base = '0; e_inst = '0;
        end else if (!m_act) begin
            if (iq && !fl) begin m_act = 1; m_base = ia; m_cnt = 0; end
        end else if (fl || !iq) begin
            m_act = 0;
        end else if (m_cnt < 4 && mq) begin
            m_cnt = 0;
        end else if (m_cnt < 4) begin
            m_b[m_cnt] = mem[AW'(m_base + m_cnt)];
            m_cnt++;
        end else begin
            e_done = 1; e_inst = {m_b[3], m_b[2], m_b[1], m_b[0]}; m_act = 0;
        end
        @(posedge clk);
        #1;
        chk("if_done", if_done, e_done);
        chk("if_inst", if_inst, e_inst);
        chk("memctrl_data", memctrl_data, e_rd);
    endtask

    task automatic wr(input logic [31:0] a, input logic [7:0] d);
        step(0, 1, 1, a, d, 0, 0, 0);
    endtask

    task automatic fetch(input string nm, input logic [31:0] a, input logic [31:0] want,
                         input int lat, input int off);
        int k = 0;
        step(0, 0, 0, 0, 0, 1, 0, a);
        a_seq[0] = s_a;
        while (!if_done && k < 12) begin
            k++;
            step(0, 0, 0, 0, 0, 1, 0, a);
            a_seq[k] = s_a;
        end
        chk({nm, " latency"}, k, lat);
        chk({nm, " inst"}, if_inst, want);
        for (int i = 0; i < 4; i++) chk({nm, " addr seq"}, a_seq[off + i], AW'(a + i));
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    typedef struct {
        logic r, mq, rw;
        logic [31:0] ma;
        logic [7:0] md;
        logic [AW-1:0] ea;
        logic ew;
        logic [7:0] ed;
    } vec_t;

    initial begin
        vec_t tbl [6];
        int nd, nw;
        tbl[0] = '{1, 1, 1, 32'h0001_2345, 8'hAA, 17'h00000, 0, 8'h00};
        tbl[1] = '{0, 1, 1, 32'h0001_2345, 8'hAA, 17'h12345, 1, 8'hAA};
        tbl[2] = '{0, 1, 0, 32'hFFFE_1234, 8'h55, 17'h01234, 0, 8'h55};
        tbl[3] = '{0, 0, 1, 32'h0001_FFFF, 8'h77, 17'h00000, 0, 8'h00};
        tbl[4] = '{0, 1, 1, 32'hABCD_FFFF, 8'h01, 17'h1FFFF, 1, 8'h01};
        tbl[5] = '{1, 1, 0, 32'h0000_0042, 8'h99, 17'h00000, 0, 8'h00};

        for (int i = 0; i < 3; i++) begin
            step(1, 1, 1, 32'h0000_0100, 8'hFF, 1, 0, 32'h100);
            chk("reset ram_wr", s_wr, 0);
            chk("reset ram_a", s_a, 0);
            chk("reset if_done", if_done, 0);
            chk("reset if_inst", if_inst, 0);
        end

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].mq, tbl[i].rw, tbl[i].ma, tbl[i].md, 0, 0, 0);
            chk("vec ram_a", s_a, tbl[i].ea);
            chk("vec ram_wr", s_wr, tbl[i].ew);
            chk("vec ram_dout", s_d, tbl[i].ed);
        end

        wr(32'h100, 8'h13); wr(32'h101, 8'h05); wr(32'h102, 8'h10); wr(32'h103, 8'h00);
        wr(32'h104, 8'h93); wr(32'h105, 8'h05); wr(32'h106, 8'h20); wr(32'h107, 8'h00);
        wr(32'h200, 8'h5A);
        wr(32'h1FFFE, 8'h11); wr(32'h1FFFF, 8'h22); wr(32'h0, 8'h33); wr(32'h1, 8'h44);
        fetch("plain", 32'h100, 32'h0010_0513, 5, 1);

        nw = 0;
        wr(32'h1000, 8'hEF); nw += int'(s_wr);
        wr(32'h1001, 8'hBE); nw += int'(s_wr);
        wr(32'h1002, 8'hAD); nw += int'(s_wr);
        wr(32'h1003, 8'hDE); nw += int'(s_wr);
        step(0, 0, 0, 0, 0, 0, 0, 0); nw += int'(s_wr);
        chk("word write count", nw, 4);
        fetch("readback", 32'h1000, 32'hDEAD_BEEF, 5, 1);

        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 0, 32'h100);
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 0, 32'h200, 8'h00, 1, 0, 32'h100);
            if (i == 0) begin
                chk("preempt ram_a", s_a, 17'h200);
                chk("preempt read data", memctrl_data, 8'h5A);
            end
        end
        fetch("preempt", 32'h100, 32'h0010_0513, 4, 0);

        nd = 0;
        for (int i = 0; i < 4; i++) begin step(0, 0, 0, 0, 0, 1, 0, 32'h100); nd += int'(if_done); end
        step(0, 0, 0, 0, 0, 1, 1, 32'h100); nd += int'(if_done);
        for (int i = 0; i < 6; i++) begin step(0, 0, 0, 0, 0, 0, 0, 0); nd += int'(if_done); end
        chk("flush no done", nd, 0);
        fetch("after flush", 32'h104, 32'h0020_0593, 5, 1);

        fetch("wrap", 32'h1FFFE, 32'h4433_2211, 5, 1);

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] ra, ia;
            ra = ($urandom & 32'hFFFE_0000) | 32'($urandom_range(32'h100, 32'h13F));
            ia = ($urandom_range(0, 7) == 0) ? 32'h1FFFD : 32'($urandom_range(32'h100, 32'h13C));
            step($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 3, 1'($urandom),
                 ra, 8'($urandom), $urandom_range(0, 19) < 17, $urandom_range(0, 31) == 0, ia);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
